// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging execute to a 32-bit byte-lane bus.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [2:0]        req_rdest,
    input  logic [31:0]       req_store_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_write_enable,
    output logic [2:0]        wb_rdest,
    output logic [1:0]        wb_data_size,
    output logic [31:0]       wb_data,
    output logic              busy,
    output logic              fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, WB} state_e;

    state_e            state_q, state_d;
    logic              is_store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [2:0]        rdest_q;
    logic [31:0]       sdata_q;
    logic [31:0]       wb_data_q;
    logic              fault_q;

    logic        accept;
    logic        misalign;
    logic        timeout;
    logic [1:0]  off;
    logic [3:0]  base_be;
    logic [31:0] sdata_m;
    logic [31:0] lane;
    logic [31:0] ext;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign accept   = (state_q == IDLE) && req_valid;
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
    assign off      = addr_q[1:0];

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expiry is the cycle the counter would reach the limit; a response then still wins.
    assign timeout = (state_q == WAIT_RSP) && !mem_rsp_valid &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == REQ)
            cnt_d = '0;
        else if ((state_q == WAIT_RSP) && !mem_rsp_valid)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept && !misalign) state_d = REQ;
            REQ:      if (mem_req_ready) state_d = is_store_q ? IDLE : WAIT_RSP;
            WAIT_RSP: begin
                if (mem_rsp_valid) state_d = WB;
                else if (timeout)  state_d = IDLE;
            end
            WB:       state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'b00:   base_be = 4'b0001;
            2'b01:   base_be = 4'b0011;
            default: base_be = 4'b1111;
        endcase
        unique case (size_q)
            2'b00:   sdata_m = {24'b0, sdata_q[7:0]};
            2'b01:   sdata_m = {16'b0, sdata_q[15:0]};
            default: sdata_m = sdata_q;
        endcase
        lane = mem_rdata >> {off, 3'b000};
        unique case (size_q)
            2'b00:   ext = {{24{sign_q & lane[7]}}, lane[7:0]};
            2'b01:   ext = {{16{sign_q & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == IDLE);
        busy            = (state_q != IDLE);
        mem_req_valid   = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_be          = 4'b0000;
        mem_wdata       = 32'b0;
        wb_write_enable = 1'b0;
        wb_rdest        = 3'b0;
        wb_data_size    = 2'b10;
        wb_data         = wb_data_q;
        fault           = fault_q | timeout;
        if (state_q == REQ) begin
            mem_req_valid = 1'b1;
            mem_we        = is_store_q;
            mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
            mem_be        = base_be << off;
            mem_wdata     = sdata_m << {off, 3'b000};
        end
        if (state_q == WB) begin
            wb_write_enable = 1'b1;
            wb_rdest        = rdest_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q <= 1'b0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            rdest_q    <= 3'b0;
            sdata_q    <= 32'b0;
            wb_data_q  <= 32'b0;
            fault_q    <= 1'b0;
        end else begin
            fault_q <= accept && misalign;
            if (accept && !misalign) begin
                is_store_q <= req_is_store;
                addr_q     <= req_addr;
                size_q     <= req_size;
                sign_q     <= req_sign;
                rdest_q    <= req_rdest;
                sdata_q    <= req_store_data;
            end
            if ((state_q == WAIT_RSP) && mem_rsp_valid)
                wb_data_q <= ext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit; the bus side is played
// by the stimulus process while an independent monitor checks every output.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store, req_sign;
    logic [31:0] req_addr, req_store_data;
    logic [1:0]  req_size;
    logic [2:0]  req_rdest;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_write_enable, busy, fault;
    logic [2:0]  wb_rdest;
    logic [1:0]  wb_data_size;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_addr(req_addr),
        .req_size(req_size), .req_sign(req_sign),
        .req_rdest(req_rdest), .req_store_data(req_store_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .wb_write_enable(wb_write_enable),
        .wb_rdest(wb_rdest), .wb_data_size(wb_data_size),
        .wb_data(wb_data), .busy(busy), .fault(fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [2:0]  rdest;
        logic [31:0] data;
        int          lat;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   fault_exp = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic mon_en = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(logic [31:0] a, logic [1:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    // Reference load result: pick the addressed bytes, then extend arithmetically.
    function automatic logic [31:0] ld_model(logic [31:0] rd, int off,
                                             logic [1:0] sz, logic sg);
        longint lane, v, span;
        lane = longint'(rd) >> (8 * off);
        span = longint'(1) << (8 * nbytes(sz));
        v    = lane % span;
        if (sg && nbytes(sz) < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic bus_t bus_model(logic st, logic [31:0] a,
                                       logic [1:0] sz, logic [31:0] d);
        bus_t   b;
        longint span, w;
        int     off;
        off     = a % 4;
        span    = longint'(1) << (8 * nbytes(sz));
        w       = (longint'(d) % span) << (8 * off);
        b.addr  = a - off;
        b.be    = 4'(((1 << nbytes(sz)) - 1) << off);
        b.we    = st;
        b.wdata = w[31:0];
        return b;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst && mon_en) begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (mem_req_valid) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_req_valid), 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, bus_q[0].addr);
                    chk("mem_be", 32'(mem_be), 32'(bus_q[0].be));
                    chk("mem_we", 32'(mem_we), 32'(bus_q[0].we));
                    if (bus_q[0].we) chk("mem_wdata", mem_wdata, bus_q[0].wdata);
                    if (mem_req_ready) void'(bus_q.pop_front());
                end
            end
            if (wb_write_enable) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", 32'(wb_write_enable), 32'd0);
                end else begin
                    chk("wb_rdest", 32'(wb_rdest), 32'(wb_q[0].rdest));
                    chk("wb_data", wb_data, wb_q[0].data);
                    chk("wb_latency", 32'(cyc - acc_cyc), 32'(wb_q[0].lat));
                    void'(wb_q.pop_front());
                end
            end
            if (fault) begin
                if (fault_exp == 0) chk("unexpected_fault", 32'(fault), 32'd0);
                else fault_exp--;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic accept(input logic st, input logic [31:0] a,
                          input logic [1:0] sz, input logic sg,
                          input logic [2:0] rd, input logic [31:0] sd);
        wait_ready();
        req_valid      = 1'b1;
        req_is_store   = st;
        req_addr       = a;
        req_size       = sz;
        req_sign       = sg;
        req_rdest      = rd;
        req_store_data = sd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic bus_hs(input int dly, input logic noise);
        repeat (dly) begin
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        if (noise) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = $urandom;
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic do_access(input logic st, input logic [31:0] a,
                             input logic [1:0] sz, input logic sg,
                             input logic [2:0] rd, input logic [31:0] sd,
                             input logic [31:0] rdat, input int rdy_dly,
                             input int rsp_dly, input logic noise);
        wb_t w;
        if (is_mis(a, sz)) begin
            fault_exp++;
            accept(st, a, sz, sg, rd, sd);
            chk("mis_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            return;
        end
        bus_q.push_back(bus_model(st, a, sz, sd));
        if (!st) begin
            w.rdest = rd;
            w.data  = ld_model(rdat, a % 4, sz, sg);
            w.lat   = 3 + rdy_dly + rsp_dly;
            wb_q.push_back(w);
        end
        accept(st, a, sz, sg, rd, sd);
        bus_hs(rdy_dly, noise);
        if (st) return;
        repeat (rsp_dly) begin
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdat;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_wb_en"}, 32'(wb_write_enable), 32'd0);
        chk({tag, "_wb_rdest"}, 32'(wb_rdest), 32'd0);
        chk({tag, "_wb_size"}, 32'(wb_data_size), 32'd2);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic        st, sg;
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0;
        req_size = '0; req_sign = 1'b0; req_rdest = '0;
        req_store_data = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs("reset");
        mon_en = 1'b1;

        do_access(1'b0, 32'h1003, 2'b00, 1'b1, 3'd5, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
        do_access(1'b0, 32'h2002, 2'b01, 1'b0, 3'd2, 32'h0, 32'hBEEF_1234, 0, 0, 1'b0);
        do_access(1'b1, 32'h3001, 2'b00, 1'b0, 3'd0, 32'h1234_56AB, 32'h0, 3, 0, 1'b0);
        do_access(1'b0, 32'h4002, 2'b10, 1'b0, 3'd1, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access(1'b0, 32'h5000, 2'b10, 1'b1, 3'd7, 32'h0, 32'h8765_4321, 1, 2, 1'b1);

        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
            do_access(st, a, sz, sg, 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end

        // Abort a load in WAIT_RSP; the late response must be dropped.
        bus_q.push_back(bus_model(1'b0, 32'h6004, 2'b10, 32'h0));
        accept(1'b0, 32'h6004, 2'b10, 1'b0, 3'd3, 32'h0);
        bus_hs(0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1;

`ifdef LSU_TIMEOUT_EN
        bus_q.push_back(bus_model(1'b0, 32'h7000, 2'b10, 32'h0));
        fault_exp++;
        accept(1'b0, 32'h7000, 2'b10, 1'b0, 3'd4, 32'h0);
        bus_hs(0, 1'b0);
        repeat (TO + 2) @(posedge clk);
        #1;
        chk("timeout_busy", 32'(busy), 32'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        chk("faults_seen", 32'(fault_exp), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
